// File: rtl/audctl_reg.sv
// POKEY AUDCTL register: 8-bit control word loaded on POKEY clock enable pulses.
// Define AUDCTL_READBACK_EN to expose the whole register on audctl_q for CPU read-back.
module audctl_reg #(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enn,
  input  logic       wren,
  input  logic [7:0] D,
  output logic       sel15Khz,
  output logic       disHiFltr2,
  output logic       disHiFltr1,
  output logic       ch4Bits16,
  output logic       ch2Bits16,
  output logic       enFastClk3,
  output logic       enFastClk1,
`ifdef AUDCTL_READBACK_EN
  output logic       sel9bitPoly,
  output logic [7:0] audctl_q
`else
  output logic       sel9bitPoly
`endif
);

  localparam int unsigned W = 8;

  logic [W-1:0] ctl_q;
  logic [W-1:0] ctl_d;

  // Whole-word load only on a POKEY clock pulse with a pending write
  always_comb begin
    ctl_d = ctl_q;
    if (enn && wren) begin
      ctl_d = D;
    end
  end

  // Synchronous reset takes priority over a coincident write
  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_q <= RESET_VAL;
    end else begin
      ctl_q <= ctl_d;
    end
  end

  assign sel15Khz    = ctl_q[0];
  assign disHiFltr2  = ctl_q[1];
  assign disHiFltr1  = ctl_q[2];
  assign ch4Bits16   = ctl_q[3];
  assign ch2Bits16   = ctl_q[4];
  assign enFastClk3  = ctl_q[5];
  assign enFastClk1  = ctl_q[6];
  assign sel9bitPoly = ctl_q[7];

`ifdef AUDCTL_READBACK_EN
  assign audctl_q = ctl_q;
`endif

endmodule

// File: tb/tb_audctl_reg.sv
// Scoreboard bench for audctl_reg: stimulus queues expected register words,
// a negedge monitor pops and compares them against the output bits.
module tb_audctl_reg;

  logic       clk;
  logic       reset;
  logic       enn;
  logic       wren;
  logic [7:0] D;
  logic       sel15Khz, disHiFltr2, disHiFltr1, ch4Bits16;
  logic       ch2Bits16, enFastClk3, enFastClk1, sel9bitPoly;
`ifdef AUDCTL_READBACK_EN
  logic [7:0] audctl_q;
`endif

  int checks;
  int failures;

  logic [7:0] exp_q[$];
  string      name_q[$];

  audctl_reg dut (
    .clk        (clk),
    .reset      (reset),
    .enn        (enn),
    .wren       (wren),
    .D          (D),
    .sel15Khz   (sel15Khz),
    .disHiFltr2 (disHiFltr2),
    .disHiFltr1 (disHiFltr1),
    .ch4Bits16  (ch4Bits16),
    .ch2Bits16  (ch2Bits16),
    .enFastClk3 (enFastClk3),
    .enFastClk1 (enFastClk1),
`ifdef AUDCTL_READBACK_EN
    .sel9bitPoly(sel9bitPoly),
    .audctl_q   (audctl_q)
`else
    .sel9bitPoly(sel9bitPoly)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Monitor: one expected word per cycle, sampled mid-cycle
  always @(negedge clk) begin
    logic [7:0] obs;
    logic [7:0] exp;
    string      nm;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      obs = {sel9bitPoly, enFastClk1, enFastClk3, ch2Bits16,
             ch4Bits16, disHiFltr1, disHiFltr2, sel15Khz};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL %s: outputs=%h expected=%h", nm, obs, exp);
      end
`ifdef AUDCTL_READBACK_EN
      checks++;
      if (audctl_q !== exp) begin
        failures++;
        $display("FAIL %s_readback: audctl_q=%h expected=%h", nm, audctl_q, exp);
      end
`endif
    end
  end

  // Apply one cycle of inputs, then queue the word expected after that edge
  task automatic step(input logic r, input logic e, input logic w,
                      input logic [7:0] d, input logic [7:0] exp, input string nm);
    reset = r;
    enn   = e;
    wren  = w;
    D     = d;
    @(posedge clk);
    #1;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset = 1'b1;
    enn   = 1'b0;
    wren  = 1'b0;
    D     = 8'h00;
    @(posedge clk);
    #1;

    //    rst   enn   wren  D      expected
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, "reset_value");
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, "idle_after_reset");
    step(1'b0, 1'b1, 1'b1, 8'hF1, 8'hF1, "write_f1");
    step(1'b0, 1'b0, 1'b1, 8'h04, 8'hF1, "d_change_no_enn");
    step(1'b0, 1'b1, 1'b1, 8'h04, 8'h04, "write_04");
    step(1'b0, 1'b1, 1'b1, 8'h03, 8'h03, "write_03");
    step(1'b0, 1'b1, 1'b0, 8'hFF, 8'h03, "enn_without_wren");
    step(1'b0, 1'b1, 1'b1, 8'hF9, 8'hF9, "write_f9");
    step(1'b0, 1'b0, 1'b1, 8'hFF, 8'hF9, "wren_hold_1");
    step(1'b0, 1'b0, 1'b1, 8'hFF, 8'hF9, "wren_hold_2");
    step(1'b0, 1'b0, 1'b1, 8'hFF, 8'hF9, "wren_hold_3");
    step(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, "first_enn_ff");
    step(1'b0, 1'b1, 1'b1, 8'h5A, 8'h5A, "multi_pulse_1");
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'h5A, "multi_pulse_gap");
    step(1'b0, 1'b1, 1'b1, 8'hA5, 8'hA5, "multi_pulse_last");
    step(1'b1, 1'b1, 1'b1, 8'hAA, 8'h00, "reset_over_write");
    step(1'b0, 1'b1, 1'b1, 8'h3C, 8'h3C, "write_after_reset");
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h3C, "final_hold");

    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
